// File: rtl/uncache_axi_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uncache_axi_unit_pkg
// Description : Shared constants for the uncached AXI bridge: FSM state
//               encoding and the AXI4 burst/response/size codes it drives.
// Revision    : 1.0 - initial release
// ============================================================================
package uncache_axi_unit_pkg;

  // FSM state encoding (5 states, 3 bits)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_RESP = 3'd4;

  // AXI4 encodings
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_B     = 3'd0;
  localparam logic [2:0] SIZE_H     = 3'd1;
  localparam logic [2:0] SIZE_W     = 3'd2;

endpackage
`default_nettype wire

// File: rtl/uncache_axi_unit.sv
`default_nettype none
// ============================================================================
// Module      : uncache_axi_unit
// Description : Converts one uncached load/store from the MEM stage into a
//               single-beat AXI4 transaction (AR/R or AW/W/B) and returns a
//               registered completion pulse with load data / error flag.
//               One transaction in flight at most.
// Ports       : clk, rst            - clock, async active-high reset
//               req_*               - uncached request / completion port
//               ar*, r*             - AXI read address / data channels
//               aw*, w*, b*         - AXI write address / data / resp channels
// Revision    : 1.0 - initial release
// ============================================================================
module uncache_axi_unit
  import uncache_axi_unit_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = 4'd1
) (
  input  logic            clk,
  input  logic            rst,
  // request port
  input  logic            req_valid,
  input  logic            req_op,
  input  logic [19:0]     req_tag,
  input  logic [7:0]      req_index,
  input  logic [3:0]      req_offset,
  input  logic [3:0]      req_wstrb,
  input  logic [31:0]     req_wdata,
  input  logic [2:0]      req_arsize,
  input  logic [2:0]      req_awsize,
  output logic            req_addr_ok,
  output logic            req_data_ok,
  output logic [31:0]     req_rdata,
  output logic            req_err,
  // AXI read address
  output logic [ID_W-1:0] arid,
  output logic            arvalid,
  output logic [31:0]     araddr,
  output logic [2:0]      arsize,
  output logic [7:0]      arlen,
  output logic [1:0]      arburst,
  output logic            arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  input  logic            arready,
  // AXI read data
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  // AXI write address
  output logic [ID_W-1:0] awid,
  output logic            awvalid,
  output logic [31:0]     awaddr,
  output logic [2:0]      awsize,
  output logic [7:0]      awlen,
  output logic [1:0]      awburst,
  input  logic            awready,
  // AXI write data
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  // AXI write response
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  logic [2:0]  r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_rdata;
  logic        r_data_ok;
  logic        r_err;

  logic w_accept;
  logic w_ar_hs;
  logic w_r_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;
  logic w_wr_both_done;
  logic w_unused_axi;

  // Single ID, single outstanding transaction: response IDs and rlast carry
  // no information here.
  assign w_unused_axi = ^{rid, rlast, bid};

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_ar_hs  = arvalid && arready;
  assign w_r_hs   = (r_state == ST_RD_DATA) && rvalid;
  assign w_aw_hs  = awvalid && awready;
  assign w_w_hs   = wvalid && wready;
  assign w_b_hs   = (r_state == ST_WR_RESP) && bvalid;

  // Includes the cycle in which the later of the two handshakes lands.
  assign w_wr_both_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_accept) r_state <= req_op ? ST_WR_REQ : ST_RD_ADDR;
        ST_RD_ADDR: if (w_ar_hs) r_state <= ST_RD_DATA;
        ST_RD_DATA: if (w_r_hs) r_state <= ST_IDLE;
        ST_WR_REQ:  if (w_wr_both_done) r_state <= ST_WR_RESP;
        ST_WR_RESP: if (w_b_hs) r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  // Request latch: held constant for the whole transaction, which keeps the
  // AXI address/data/size stable while any VALID is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 32'h0;
      r_size  <= 3'd0;
      r_wstrb <= 4'h0;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_addr  <= {req_tag, req_index, req_offset};
      r_size  <= req_op ? req_awsize : req_arsize;
      r_wstrb <= req_wstrb;
      r_wdata <= req_wdata;
    end
  end

  // Read path: capture returned data on the R handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'h0;
    end else if (w_r_hs) begin
      r_rdata <= rdata;
    end
  end

  // Write path: per-channel done flags so AW and W may complete in any order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_accept) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (r_state == ST_WR_REQ) begin
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs)  r_w_done  <= 1'b1;
    end
  end

  // Registered completion: one-cycle pulse after the R or B handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_ok <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_data_ok <= w_r_hs || w_b_hs;
      r_err     <= (w_r_hs && (rresp != RESP_OKAY)) ||
                   (w_b_hs && (bresp != RESP_OKAY));
    end
  end

  assign req_addr_ok = w_accept;
  assign req_data_ok = r_data_ok;
  assign req_rdata   = r_rdata;
  assign req_err     = r_err;

  assign arid    = AXI_ID;
  assign arvalid = (r_state == ST_RD_ADDR);
  assign araddr  = r_addr;
  assign arsize  = r_size;
  assign arlen   = 8'd0;
  assign arburst = BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = (r_state == ST_RD_DATA);

  assign awid    = AXI_ID;
  assign awvalid = (r_state == ST_WR_REQ) && !r_aw_done;
  assign awaddr  = r_addr;
  assign awsize  = r_size;
  assign awlen   = 8'd0;
  assign awburst = BURST_INCR;

  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = (r_state == ST_WR_REQ) && !r_w_done;

  assign bready  = (r_state == ST_WR_RESP);

endmodule
`default_nettype wire

// File: tb/tb_uncache_axi_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_uncache_axi_unit
// Description : Self-checking bench for uncache_axi_unit. A word-addressed
//               memory model acts as the AXI slave; each transaction is
//               checked cycle by cycle against the expected protocol timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uncache_axi_unit;
  import uncache_axi_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_op;
  logic [19:0] req_tag;
  logic [7:0]  req_index;
  logic [3:0]  req_offset, req_wstrb;
  logic [31:0] req_wdata;
  logic [2:0]  req_arsize, req_awsize;
  logic        req_addr_ok, req_data_ok, req_err;
  logic [31:0] req_rdata;
  logic [3:0]  arid, rid, awid, bid;
  logic        arvalid, arready, arlock;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize;
  logic [7:0]  arlen, awlen;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  arcache, wstrb;
  logic        rlast, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;

  uncache_axi_unit #(.ID_W(4), .AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_tag(req_tag),
    .req_index(req_index), .req_offset(req_offset), .req_wstrb(req_wstrb),
    .req_wdata(req_wdata), .req_arsize(req_arsize), .req_awsize(req_awsize),
    .req_addr_ok(req_addr_ok), .req_data_ok(req_data_ok),
    .req_rdata(req_rdata), .req_err(req_err),
    .arid(arid), .arvalid(arvalid), .araddr(araddr), .arsize(arsize),
    .arlen(arlen), .arburst(arburst), .arlock(arlock), .arcache(arcache),
    .arprot(arprot), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awvalid(awvalid), .awaddr(awaddr), .awsize(awsize),
    .awlen(awlen), .awburst(awburst), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Slave memory model, keyed by word address.
  logic [31:0] mem [int unsigned];

  // Expected completion owed by the DUT in the next cycle.
  bit          pend = 0;
  bit          pend_load = 0;
  logic [31:0] pend_rdata = 32'h0;
  logic        pend_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [19:0] t, input logic [7:0] i,
                                           input logic [3:0] o);
    return {12'h0, t} * 32'd4096 + {24'h0, i} * 32'd16 + {28'h0, o};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    int unsigned k = a / 4;
    if (mem.exists(k)) return mem[k];
    return (a & 32'hFFFF_FFFC) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check_completion();
    if (pend) begin
      chk("data_ok", {31'h0, req_data_ok}, 32'd1);
      chk("err", {31'h0, req_err}, {31'h0, pend_err});
      if (pend_load) chk("rdata", req_rdata, pend_rdata);
      pend = 0;
    end else begin
      chk("data_ok_quiet", {31'h0, req_data_ok}, 32'd0);
      chk("err_quiet", {31'h0, req_err}, 32'd0);
    end
  endtask

  task automatic present(input logic op, input logic [19:0] t, input logic [7:0] i,
                         input logic [3:0] o, input logic [2:0] sz,
                         input logic [3:0] ws, input logic [31:0] wd);
    req_valid = 1'b1; req_op = op; req_tag = t; req_index = i; req_offset = o;
    req_wstrb = ws; req_wdata = wd;
    req_arsize = op ? 3'($urandom_range(0, 2)) : sz;
    req_awsize = op ? sz : 3'($urandom_range(0, 2));
  endtask

  task automatic idle();
    @(negedge clk);
    check_completion();
    chk("addr_ok_idle", {31'h0, req_addr_ok}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input logic [19:0] t, input logic [7:0] i, input logic [3:0] o,
                         input logic [2:0] sz, input int ar_wait, input int r_wait,
                         input logic [1:0] resp);
    logic [31:0] a;
    a = addr_of(t, i, o);
    present(1'b0, t, i, o, sz, 4'h0, 32'h0);
    @(negedge clk);
    check_completion();
    chk("ld_addr_ok", {31'h0, req_addr_ok}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < ar_wait; k++) begin
      arready = 1'b0; req_valid = 1'b1;
      @(negedge clk);
      chk("ar_stall_valid", {31'h0, arvalid}, 32'd1);
      chk("ar_stall_addr", araddr, a);
      chk("ar_stall_size", {29'h0, arsize}, {29'h0, sz});
      chk("ar_stall_addr_ok", {31'h0, req_addr_ok}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; arready = 1'b1;
    @(negedge clk);
    chk("arvalid", {31'h0, arvalid}, 32'd1);
    chk("araddr", araddr, a);
    chk("arsize", {29'h0, arsize}, {29'h0, sz});
    chk("ar_data_ok", {31'h0, req_data_ok}, 32'd0);
    @(posedge clk); #1;
    arready = 1'b0;
    for (int k = 0; k < r_wait; k++) begin
      @(negedge clk);
      chk("rready_wait", {31'h0, rready}, 32'd1);
      chk("arvalid_low", {31'h0, arvalid}, 32'd0);
      chk("r_wait_data_ok", {31'h0, req_data_ok}, 32'd0);
      @(posedge clk); #1;
    end
    rvalid = 1'b1; rdata = mem_rd(a); rresp = resp;
    rid = 4'($urandom); rlast = 1'b1;
    @(negedge clk);
    chk("rready", {31'h0, rready}, 32'd1);
    chk("r_data_ok", {31'h0, req_data_ok}, 32'd0);
    @(posedge clk); #1;
    rvalid = 1'b0; rdata = $urandom;
    pend = 1; pend_load = 1; pend_rdata = mem_rd(a); pend_err = (resp != RESP_OKAY);
  endtask

  task automatic do_store(input logic [19:0] t, input logic [7:0] i, input logic [3:0] o,
                          input logic [2:0] sz, input logic [3:0] ws, input logic [31:0] wd,
                          input int aw_lat, input int w_lat, input int b_wait,
                          input logic [1:0] resp);
    logic [31:0] a;
    logic [31:0] m;
    bit aw_d, w_d;
    int last;
    a = addr_of(t, i, o);
    present(1'b1, t, i, o, sz, ws, wd);
    @(negedge clk);
    check_completion();
    chk("st_addr_ok", {31'h0, req_addr_ok}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    aw_d = 0; w_d = 0;
    last = (aw_lat > w_lat) ? aw_lat : w_lat;
    for (int c = 0; c <= last; c++) begin
      awready = (c == aw_lat); wready = (c == w_lat);
      @(negedge clk);
      chk("awvalid", {31'h0, awvalid}, {31'h0, !aw_d});
      chk("wvalid", {31'h0, wvalid}, {31'h0, !w_d});
      if (!aw_d) begin
        chk("awaddr", awaddr, a);
        chk("awsize", {29'h0, awsize}, {29'h0, sz});
      end
      if (!w_d) begin
        chk("wdata", wdata, wd);
        chk("wstrb", {28'h0, wstrb}, {28'h0, ws});
        chk("wlast", {31'h0, wlast}, 32'd1);
      end
      chk("bready_early", {31'h0, bready}, 32'd0);
      @(posedge clk); #1;
      if (c == aw_lat) aw_d = 1;
      if (c == w_lat)  w_d = 1;
    end
    awready = 1'b0; wready = 1'b0;
    for (int k = 0; k < b_wait; k++) begin
      @(negedge clk);
      chk("bready_wait", {31'h0, bready}, 32'd1);
      chk("aw_w_low", {30'h0, awvalid, wvalid}, 32'd0);
      @(posedge clk); #1;
    end
    bvalid = 1'b1; bresp = resp; bid = 4'($urandom);
    @(negedge clk);
    chk("bready", {31'h0, bready}, 32'd1);
    chk("b_data_ok", {31'h0, req_data_ok}, 32'd0);
    @(posedge clk); #1;
    bvalid = 1'b0;
    m = mem_rd(a);
    for (int b = 0; b < 4; b++)
      if (ws[b]) m[b*8 +: 8] = wd[b*8 +: 8];
    mem[a / 4] = m;
    pend = 1; pend_load = 0; pend_err = (resp != RESP_OKAY);
  endtask

  initial begin
    logic [19:0] tags [3];
    logic [2:0]  sz;
    logic [3:0]  off;
    logic [1:0]  rsp;
    tags[0] = 20'h1FAF0; tags[1] = 20'h00123; tags[2] = 20'h0ABCD;

    req_valid = 0; req_op = 0; req_tag = 0; req_index = 0; req_offset = 0;
    req_wstrb = 0; req_wdata = 0; req_arsize = 0; req_awsize = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {27'h0, arvalid, awvalid, wvalid, rready, bready}, 32'd0);
    chk("rst_req", {29'h0, req_addr_ok, req_data_ok, req_err}, 32'd0);
    chk("rst_rdata", req_rdata, 32'h0);
    rst = 1'b0;
    idle();

    // zero-wait load
    mem[32'h1FAF0124 / 4] = 32'hDEADBEEF;
    do_load(20'h1FAF0, 8'h12, 4'h4, SIZE_W, 0, 0, RESP_OKAY);
    idle(); idle();

    // store, W two cycles before AW
    do_store(20'h00123, 8'h40, 4'h0, SIZE_H, 4'b1100, 32'hABCD0000, 2, 0, 0, RESP_OKAY);
    idle();

    // AR back-pressure, then read back the merged store data
    do_load(20'h00123, 8'h40, 4'h0, SIZE_W, 5, 1, RESP_OKAY);
    idle();

    // SLVERR on B
    do_store(20'h0ABCD, 8'h01, 4'h8, SIZE_B, 4'b0001, 32'h000000A5, 0, 0, 2, 2'b10);
    idle(); idle();

    // back-to-back: store accepted in the load's data_ok cycle
    do_load(20'h1FAF0, 8'h12, 4'h4, SIZE_W, 0, 0, RESP_OKAY);
    do_store(20'h1FAF0, 8'h12, 4'h4, SIZE_W, 4'b0000, 32'h12345678, 0, 0, 0, RESP_OKAY);
    idle();

    // reset while in RD_DATA with rvalid low
    present(1'b0, 20'h0ABCD, 8'h33, 4'h0, SIZE_W, 4'h0, 32'h0);
    @(negedge clk);
    check_completion();
    chk("mid_addr_ok", {31'h0, req_addr_ok}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
    @(negedge clk);
    chk("mid_rready", {31'h0, rready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valids", {30'h0, arvalid, rready}, 32'd0);
    chk("rst_async_data_ok", {31'h0, req_data_ok}, 32'd0);
    chk("rst_async_rdata", req_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    do_load(20'h1FAF0, 8'h12, 4'h4, SIZE_W, 1, 0, RESP_OKAY);
    idle();

    // randomized traffic against the memory model
    for (int n = 0; n < 30; n++) begin
      sz  = 3'($urandom_range(0, 2));
      off = 4'($urandom_range(0, 15));
      off = off & ~((4'd1 << sz) - 4'd1);
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
      if ($urandom_range(0, 1) == 1)
        do_store(tags[$urandom_range(0, 2)], 8'($urandom_range(0, 1)), off, sz,
                 4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), rsp);
      else
        do_load(tags[$urandom_range(0, 2)], 8'($urandom_range(0, 1)), off, sz,
                $urandom_range(0, 3), $urandom_range(0, 3), rsp);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle(); idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uncache_axi_unit.md
Name: uncache_axi_unit

Overview:
- Downstream consumer of the data-memory decoder's uncached request port (valid/op/tag/index/offset/wstrb/size).
- Turns each uncached load or store into exactly one single-beat AXI4 transaction: AR/R for loads, AW/W/B for stores.
- Returns completion and load data to the memory stage.
- At most one transaction in flight; sits between the MEM stage and the AXI crossbar master port.

Parameters:
- AXI_ID, 4'd1: constant ARID/AWID driven on every transaction.
- ID_W, 4: width of the AXI ID fields.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  uncached request valid
- req_op  in  1  0=load, 1=store
- req_tag  in  20  physical tag (upper 3 bits already zero)
- req_index  in  8  address bits [11:4]
- req_offset  in  4  address bits [3:0]
- req_wstrb  in  4  byte strobes
- req_wdata  in  32  lane-aligned store data
- req_arsize  in  3  load size (0/1/2)
- req_awsize  in  3  store size (0/1/2)
- req_addr_ok  out  1  request accepted this cycle
- req_data_ok  out  1  one-cycle completion pulse
- req_rdata  out  32  load data, valid while req_data_ok is high
- req_err  out  1  resp!=OKAY on the completing beat; qualified by req_data_ok
- arid, arvalid, araddr, arsize, arready: AXI read-address channel (ID_W/1/32/3/1); arlen=0, arburst=INCR, arlock/arcache/arprot tied 0
- rid, rdata, rresp, rlast, rvalid, rready: AXI read-data channel
- awid, awvalid, awaddr, awsize, awready: AXI write-address channel; awlen=0, awburst=INCR
- wdata, wstrb, wlast, wvalid, wready: AXI write-data channel; wlast=1
- bid, bresp, bvalid, bready: AXI write-response channel

Behaviour:
- Address is {req_tag, req_index, req_offset}. It is latched together with op, wstrb, wdata and size on acceptance.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE:
  - req_addr_ok = req_valid (combinational, acceptance in the same cycle).
  - On accept, go to RD_ADDR for a load or WR_REQ for a store.
  - In every other state req_addr_ok = 0.
- RD_ADDR:
  - arvalid=1, holding the latched address and size.
  - On arvalid&arready, go to RD_DATA. The ARVALID/ARADDR/ARSIZE rule in "AXI source rules" applies.
- RD_DATA:
  - rready=1.
  - On rvalid, register rdata and rresp, then go to IDLE.
  - req_data_ok pulses in the cycle after the R handshake (registered), with req_rdata stable that cycle.
- WR_REQ:
  - awvalid and wvalid are both asserted on entry. Per-channel done flags are set by their handshakes, and each VALID drops after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - Go to WR_RESP when both are done, including the cycle where the last one completes.
- WR_RESP:
  - bready=1.
  - On bvalid, go to IDLE. req_data_ok pulses the next cycle, with req_err=(bresp!=0).
- Latency with zero-wait slaves, from accept to req_data_ok:
  - load: 3 cycles (accept, AR, R, data_ok).
  - store: 3 cycles (accept, AW+W, B, data_ok).
- A new request may be accepted in the same cycle req_data_ok is high: IDLE is re-entered on the handshake cycle, and data_ok is registered.
- rid and bid are ignored; the block has a single ID and a single outstanding transaction.
- AXI source rules:
  - Once asserted, ARVALID/AWVALID/WVALID stay high until their handshake.
  - ARADDR/AWADDR/WDATA/WSTRB/sizes do not change while VALID is high.
- Upstream is never back-pressured mid-transaction. It must hold req_valid until it sees req_addr_ok, and must not issue a second request before req_data_ok.
- Reset (asynchronous, any state, including mid-burst):
  - State goes to IDLE.
  - All VALID/READY outputs, req_addr_ok, req_data_ok and req_err go to 0. req_rdata goes to 32'h0.
  - Latched address/data registers go to 0.
  - An aborted AXI transaction is not resumed; the interconnect is reset together with this block.
- req_wstrb=0 on a store is still issued on AXI, giving a no-op write that completes normally.

Decomposition:
- Shared package holds:
  - state encoding (5 states, 3 bits);
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, SIZE_B/H/W = 3'd0/1/2.
- No sub-module. The read path and write path stay as two always blocks sharing one state register.

Test Plan:
- Load, zero-wait slave:
  - Stimulus: tag=20'h1FAF0, index=8'h12, offset=4'h4, arsize=2.
  - Required: araddr=32'h1FAF0124 with arsize=2 on the cycle after accept; rdata=32'hDEADBEEF returned as req_rdata with a single req_data_ok pulse 3 cycles after accept.
- Store, W before AW:
  - Stimulus: wstrb=4'b1100, wdata=32'hABCD0000; slave asserts wready 2 cycles before awready.
  - Required: wvalid drops after its handshake; awvalid holds until awready; bready rises only after both handshakes; data_ok follows bvalid by 1 cycle.
- AR back-pressure:
  - Stimulus: arready held low for 5 cycles.
  - Required: arvalid/araddr stable for all 5 cycles; req_addr_ok=0 throughout even with req_valid high.
- Error response:
  - Stimulus: bresp=2'b10 (SLVERR).
  - Required: req_err=1 in the req_data_ok cycle, then 0 the next cycle.
- Back-to-back:
  - Stimulus: load completes; a store is presented in the req_data_ok cycle.
  - Required: accepted in that same cycle; awvalid is high the next cycle.
- Reset mid-transaction:
  - Stimulus: rst asserted while in RD_DATA with rvalid low.
  - Required: arvalid/rready/req_data_ok are 0 immediately (before the next clk edge); after release, state is IDLE and a new load proceeds normally.
